// File: rtl/multi_cycle_control_fsm.sv
// Main control sequencer for the multi-cycle RV32I core.
// Steps each instruction through fetch/decode/execute/memory/writeback phases and
// decodes the datapath enables, mux selects and ALU class code from the current phase.
module multi_cycle_control_fsm #(
  parameter int unsigned MEM_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       halt_req,
  output logic       pc_write,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op_signal,
  output logic       is_halted,
  output logic [3:0] cur_state
);

  typedef enum logic [3:0] {
    StIf    = 4'd0,
    StId    = 4'd1,
    StEx    = 4'd2,
    StMem   = 4'd3,
    StWb    = 4'd4,
    StLink  = 4'd5,
    StPcinc = 4'd6,
    StHalt  = 4'd7
  } state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [3:0] LastCnt = 4'(MEM_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_cnt;

  assign last_cnt  = (cnt_q == LastCnt);
  assign cur_state = state_q;

  // Phase sequencing: next phase from current phase, opcode and branch outcome
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIf: if (last_cnt) state_d = StId;
      StId: begin
        case (opcode)
          OpR, OpI, OpLoad, OpStore, OpBranch, OpJalr: state_d = StEx;
          OpJal:    state_d = StLink;
          OpSystem: state_d = halt_req ? StHalt : StPcinc;
          default:  state_d = StPcinc;
        endcase
      end
      StEx: begin
        case (opcode)
          OpR, OpI:        state_d = StWb;
          OpJalr:          state_d = StLink;
          OpLoad, OpStore: state_d = StMem;
          OpBranch:        state_d = alu_bcond ? StIf : StPcinc;
          default:         state_d = StIf;
        endcase
      end
      StMem: if (last_cnt) state_d = (opcode == OpLoad) ? StWb : StIf;
      StWb, StLink, StPcinc: state_d = StIf;
      StHalt: state_d = StHalt;
      default: state_d = StIf;
    endcase
  end

  // Wait counter restarts on every phase change and only advances in memory phases
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = 4'd0;
    end else if (state_q == StIf || state_q == StMem) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = 4'd0;
    end
  end

  // Phase register and wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIf;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath control decode; everything is held low while reset is asserted
  always_comb begin
    pc_write      = 1'b0;
    pc_source     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op_signal = 2'b00;
    is_halted     = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StIf: begin
          mem_read = 1'b1;
          ir_write = last_cnt;
        end
        // ALUOut <- PC + imm, speculative branch/jump target
        StId: alu_src_b = 2'b10;
        StEx: begin
          alu_src_a = 1'b1;
          case (opcode)
            OpR: alu_op_signal = 2'b10;
            OpI, OpJalr: begin
              alu_src_b     = 2'b10;
              alu_op_signal = 2'b10;
            end
            OpLoad, OpStore: alu_src_b = 2'b10;
            OpBranch: begin
              alu_op_signal = 2'b01;
              pc_write      = alu_bcond;
              pc_source     = 1'b1;
            end
            default: ;
          endcase
        end
        StMem: begin
          i_or_d = 1'b1;
          if (opcode == OpLoad) begin
            mem_read = 1'b1;
          end else if (opcode == OpStore && last_cnt) begin
            // Store retires here, so PC+4 is folded into the last memory cycle
            mem_write     = 1'b1;
            pc_write      = 1'b1;
            alu_src_b     = 2'b01;
            alu_op_signal = 2'b11;
          end
        end
        StWb: begin
          reg_write     = 1'b1;
          mem_to_reg    = (opcode == OpLoad);
          pc_write      = 1'b1;
          alu_src_b     = 2'b01;
          alu_op_signal = 2'b11;
        end
        // rd <- PC+4 from the ALU while PC takes the target held in ALUOut
        StLink: begin
          reg_write     = 1'b1;
          pc_write      = 1'b1;
          pc_source     = 1'b1;
          alu_src_b     = 2'b01;
          alu_op_signal = 2'b11;
        end
        StPcinc: begin
          pc_write      = 1'b1;
          alu_src_b     = 2'b01;
          alu_op_signal = 2'b11;
        end
        StHalt: is_halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Bench for multi_cycle_control_fsm: two instances (MEM_CYCLES 1 and 3) run independent
// instruction streams; the expected per-cycle phase and control vector come from an
// instruction-level model and are checked by a queue-based monitor.
module tb_multi_cycle_control_fsm;

  typedef struct packed {
    logic [3:0]  st;
    logic [13:0] o;
  } rec_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;
  localparam logic [6:0] OP_NOP  = 7'b1111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset     [2];
  logic [6:0] opcode    [2];
  logic       alu_bcond [2];
  logic       halt_req  [2];
  logic       pc_write  [2];
  logic       pc_source [2];
  logic       i_or_d    [2];
  logic       mem_read  [2];
  logic       mem_write [2];
  logic       ir_write  [2];
  logic       mem_to_reg[2];
  logic       reg_write [2];
  logic       alu_src_a [2];
  logic [1:0] alu_src_b [2];
  logic [1:0] alu_op    [2];
  logic       is_halted [2];
  logic [3:0] cur_state [2];
  logic [13:0] obs      [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    multi_cycle_control_fsm #(.MEM_CYCLES(g == 0 ? 1 : 3)) dut (
      .clk          (clk),
      .reset        (reset[g]),
      .opcode       (opcode[g]),
      .alu_bcond    (alu_bcond[g]),
      .halt_req     (halt_req[g]),
      .pc_write     (pc_write[g]),
      .pc_source    (pc_source[g]),
      .i_or_d       (i_or_d[g]),
      .mem_read     (mem_read[g]),
      .mem_write    (mem_write[g]),
      .ir_write     (ir_write[g]),
      .mem_to_reg   (mem_to_reg[g]),
      .reg_write    (reg_write[g]),
      .alu_src_a    (alu_src_a[g]),
      .alu_src_b    (alu_src_b[g]),
      .alu_op_signal(alu_op[g]),
      .is_halted    (is_halted[g]),
      .cur_state    (cur_state[g])
    );
    assign obs[g] = {pc_write[g], pc_source[g], i_or_d[g], mem_read[g], mem_write[g],
                     ir_write[g], mem_to_reg[g], reg_write[g], alu_src_a[g], alu_src_b[g],
                     alu_op[g], is_halted[g]};
  end

  int n_chk  = 0;
  int n_fail = 0;
  rec_t q0[$];
  rec_t q1[$];

  // Build one expected cycle: phase number plus the full control vector
  function automatic rec_t mk(int st, bit pcw, bit pcs, bit iod, bit mr, bit mw, bit irw,
                              bit m2r, bit rw, bit sa, bit [1:0] sb, bit [1:0] op, bit hl);
    rec_t r;
    r.st = 4'(st);
    r.o  = {pcw, pcs, iod, mr, mw, irw, m2r, rw, sa, sb, op, hl};
    return r;
  endfunction

  function automatic rec_t ex_phase(bit [1:0] sb, bit [1:0] op);
    return mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, sb, op, 0);
  endfunction

  function automatic rec_t wb_phase(bit ld);
    return mk(4, 1, 0, 0, 0, 0, 0, ld, 1, 0, 2'b01, 2'b11, 0);
  endfunction

  function automatic rec_t link_phase();
    return mk(5, 1, 1, 0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b11, 0);
  endfunction

  function automatic rec_t pcinc_phase();
    return mk(6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b11, 0);
  endfunction

  function automatic rec_t halt_phase();
    return mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
  endfunction

  // Instruction-level model: the cycle-by-cycle control trace of one whole instruction
  task automatic build(input int mc, input logic [6:0] opc, input bit bc, input bit hr,
                       output rec_t seq[$], output bit halted);
    seq = {};
    halted = 1'b0;
    for (int k = 0; k < mc; k++) seq.push_back(mk(0, 0, 0, 0, 1, 0, k == mc - 1, 0, 0, 0, 0, 0, 0));
    seq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0));
    case (opc)
      OP_R: begin
        seq.push_back(ex_phase(2'b00, 2'b10));
        seq.push_back(wb_phase(0));
      end
      OP_I: begin
        seq.push_back(ex_phase(2'b10, 2'b10));
        seq.push_back(wb_phase(0));
      end
      OP_LD: begin
        seq.push_back(ex_phase(2'b10, 2'b00));
        for (int k = 0; k < mc; k++) seq.push_back(mk(3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        seq.push_back(wb_phase(1));
      end
      OP_ST: begin
        seq.push_back(ex_phase(2'b10, 2'b00));
        for (int k = 0; k < mc - 1; k++) seq.push_back(mk(3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        seq.push_back(mk(3, 1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b11, 0));
      end
      OP_BR: begin
        seq.push_back(mk(2, bc, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0));
        if (!bc) seq.push_back(pcinc_phase());
      end
      OP_JALR: begin
        seq.push_back(ex_phase(2'b10, 2'b10));
        seq.push_back(link_phase());
      end
      OP_JAL: seq.push_back(link_phase());
      OP_SYS: begin
        if (hr) begin
          halted = 1'b1;
          seq.push_back(halt_phase());
        end else begin
          seq.push_back(pcinc_phase());
        end
      end
      default: seq.push_back(pcinc_phase());
    endcase
  endtask

  task automatic push(input int g, input rec_t r);
    if (g == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  // Drive one instruction; cut >= 0 stops after that many cycles
  task automatic run_instr(input int g, input logic [6:0] opc, input bit bc, input bit hr,
                           input int cut, output bit halted);
    rec_t seq[$];
    int mc = (g == 0) ? 1 : 3;
    build(mc, opc, bc, hr, seq, halted);
    for (int k = 0; k < seq.size() && (cut < 0 || k < cut); k++) begin
      @(posedge clk); #1;
      reset[g]     = 1'b0;
      opcode[g]    = opc;
      alu_bcond[g] = bc;
      halt_req[g]  = hr;
      push(g, seq[k]);
    end
  endtask

  task automatic reset_cycles(input int g, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      reset[g] = 1'b1;
      push(g, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic hold_halt(input int g, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      opcode[g]    = 7'($urandom);
      alu_bcond[g] = 1'($urandom);
      halt_req[g]  = 1'($urandom);
      push(g, halt_phase());
    end
  endtask

  task automatic run_all(input int g);
    logic [6:0] dir_op [10];
    bit         dir_bc [10];
    logic [6:0] pool   [9];
    bit h;
    int mc = (g == 0) ? 1 : 3;
    dir_op = '{OP_R, OP_LD, OP_ST, OP_BR, OP_BR, OP_JALR, OP_JAL, OP_I, OP_SYS, OP_NOP};
    dir_bc = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    pool   = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JALR, OP_JAL, OP_SYS, OP_NOP};
    reset_cycles(g, 3);
    for (int i = 0; i < 10; i++) run_instr(g, dir_op[i], dir_bc[i], 0, -1, h);
    // Reset lands in the first memory cycle of a store
    run_instr(g, OP_ST, 0, 0, mc + 2, h);
    reset_cycles(g, 1);
    run_instr(g, OP_NOP, 0, 0, -1, h);
    for (int i = 0; i < 60; i++) begin
      logic [6:0] opc;
      int sel = $urandom_range(0, 9);
      opc = (sel == 9) ? 7'($urandom) : pool[sel];
      run_instr(g, opc, 1'($urandom), ($urandom_range(0, 3) == 0), -1, h);
      if (h) begin
        hold_halt(g, $urandom_range(3, 10));
        reset_cycles(g, $urandom_range(1, 3));
      end
    end
    run_instr(g, OP_SYS, 0, 1, -1, h);
    hold_halt(g, 20);
    reset_cycles(g, 2);
    run_instr(g, OP_R, 0, 0, -1, h);
  endtask

  task automatic check(input int g, input rec_t e);
    n_chk++;
    if (cur_state[g] !== e.st) begin
      n_fail++;
      $display("FAIL state inst%0d t=%0t: got %0d expected %0d", g, $time, cur_state[g], e.st);
    end
    n_chk++;
    if (obs[g] !== e.o) begin
      n_fail++;
      $display("FAIL controls inst%0d t=%0t state=%0d: got %b expected %b",
               g, $time, e.st, obs[g], e.o);
    end
  endtask

  // Monitor: compare each presented cycle against the oldest queued expectation
  always @(negedge clk) begin
    if (q0.size() > 0) check(0, q0.pop_front());
    if (q1.size() > 0) check(1, q1.pop_front());
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      reset[g]     = 1'b1;
      opcode[g]    = 7'd0;
      alu_bcond[g] = 1'b0;
      halt_req[g]  = 1'b0;
    end
    fork
      run_all(0);
      run_all(1);
    join
    repeat (3) @(negedge clk);
    n_chk++;
    if (q0.size() + q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q0.size() + q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
